shift_serializer: RTL and testbench

- Parallel-in/serial-out transmitter.
- Accepts one Depth-beat word (Depth*Width bits) over a valid/ready handshake.
- Emits the word as Depth consecutive Width-bit beats on a valid/ready stream, with last_o on the final beat.
- Serves as the sending end feeding the datapath's shift-register/deserializer chain; sustains one beat per cycle, including back-to-back words.

---
 rtl/shift_serializer.sv | 185 ++++++++++++++++++
 tb/tb_shift_serializer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
//
// Parallel-in / serial-out transmitter. One Depth-beat word (Depth*Width bits)
// is taken over an input valid/ready handshake and sent as Depth consecutive
// Width-bit beats on an output valid/ready stream. last_o marks the final beat
// of each word. A new word can be loaded in the same cycle the last beat of the
// previous word leaves, so back-to-back words stream with no bubble.
//
// Handshake semantics (both sides): a transfer happens at a rising clk_i edge
// where valid and ready are both high. A source holding valid high keeps its
// data stable until that edge; ready may depend combinationally on the
// partner's ready (ready_o depends on ready_i) but never on the partner's
// valid, so there is no combinational loop.
//
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   rst_i    - asynchronous reset, active high
//   valid_i  - input word valid
//   ready_o  - serializer can accept a word this cycle (0 while rst_i is high)
//   d_i      - input word, Width*Depth bits; beat k is d_i[k*Width +: Width]
//   valid_o  - output beat valid
//   ready_i  - downstream accepts the current beat
//   d_o      - output beat (0 whenever valid_o is 0)
//   last_o   - current beat is beat Depth-1 of its word
//   busy_o   - a word is held; this is the FSM state (SHIFT) made visible
//
// Parameters:
//   Width    - bits per output beat
//   Depth    - beats per input word (>= 1)
//   LsbFirst - 1: beat 0 = d_i[Width-1:0] goes first; 0: top beat goes first
// -----------------------------------------------------------------------------
module shift_serializer #(
  parameter int Width    = 32,
  parameter int Depth    = 8,
  parameter int LsbFirst = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [Width*Depth-1:0]   d_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [Width-1:0]         d_o,
  output logic                     last_o,
  output logic                     busy_o
);

  localparam int              CW       = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(Depth - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  // The holding register is kept in transmit order: the beat on d_o is always
  // the lowest Width bits, and each accepted beat shifts the rest down.
  logic [Width*Depth-1:0]   r_hold;
  logic [Width*Depth-1:0]   w_load;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt_inc;
  logic                     r_last;

  logic                     w_valid;
  logic                     w_ready;
  logic                     w_word_acc;
  logic                     w_beat_acc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_word_acc) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Leaving SHIFT only when the last beat goes out and no new word
        // is loaded in the same edge.
        if (w_beat_acc && r_last && !w_word_acc) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and handshake qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    w_valid = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_valid = 1'b0;
        w_ready = 1'b1;
      end
      S_SHIFT: begin
        w_valid = 1'b1;
        // Reload is only possible as the last beat is consumed.
        w_ready = ready_i && r_last;
      end
      default: begin
        w_valid = 1'b0;
        w_ready = 1'b0;
      end
    endcase
    if (rst_i) begin
      w_ready = 1'b0;
    end
  end

  assign w_word_acc = valid_i && w_ready;
  assign w_beat_acc = w_valid && ready_i;

  assign valid_o = w_valid;
  assign ready_o = w_ready;
  assign busy_o  = (r_state == S_SHIFT);
  assign d_o     = r_hold[Width-1:0];
  assign last_o  = r_last;

  // ---------------------------------------------------------------------------
  // Load reordering: put the first-to-send beat at the bottom.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load = '0;
    for (int k = 0; k < Depth; k++) begin
      if (LsbFirst != 0) begin
        w_load[k*Width +: Width] = d_i[k*Width +: Width];
      end else begin
        w_load[k*Width +: Width] = d_i[(Depth-1-k)*Width +: Width];
      end
    end
  end

  assign w_cnt_inc = r_cnt + CW'(1);

  // ---------------------------------------------------------------------------
  // Datapath: holding register, beat counter, registered last flag.
  // A word accept while in SHIFT can only coincide with the last beat accept,
  // so checking it first covers the zero-bubble reload.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (w_word_acc) begin
      r_hold <= w_load;
      r_cnt  <= '0;
      r_last <= (Depth == 1);
    end else if (w_beat_acc) begin
      if (r_last) begin
        r_hold <= '0;
        r_cnt  <= '0;
        r_last <= 1'b0;
      end else begin
        r_hold <= r_hold >> Width;
        r_cnt  <= w_cnt_inc;
        r_last <= (w_cnt_inc == LAST_CNT);
      end
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// -----------------------------------------------------------------------------
// tb_shift_serializer
//
// Three serializer instances share one clock:
//   a : Width=32, Depth=8, LsbFirst=1
//   b : Width=32, Depth=8, LsbFirst=0 (same inputs as a)
//   c : Width=32, Depth=1
// Each instance has a queue of expected {last, data} beats. A word accepted by
// the model pushes its beats in send order; a consumed beat pops the head.
// Outputs are compared against the queue head on every falling edge; directed
// literal checks pin specific values along the way.
// -----------------------------------------------------------------------------
module tb_shift_serializer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic         valid_ab, ready_ab;
  logic [255:0] d_ab;
  logic         ready_o_a, valid_o_a, last_o_a, busy_o_a;
  logic [31:0]  d_o_a;
  logic         ready_o_b, valid_o_b, last_o_b, busy_o_b;
  logic [31:0]  d_o_b;

  logic         valid_c, ready_c;
  logic [31:0]  d_c;
  logic         ready_o_c, valid_o_c, last_o_c, busy_o_c;
  logic [31:0]  d_o_c;

  shift_serializer #(.Width(32), .Depth(8), .LsbFirst(1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_ab), .ready_o(ready_o_a), .d_i(d_ab),
    .valid_o(valid_o_a), .ready_i(ready_ab), .d_o(d_o_a),
    .last_o(last_o_a), .busy_o(busy_o_a)
  );

  shift_serializer #(.Width(32), .Depth(8), .LsbFirst(0)) u_b (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_ab), .ready_o(ready_o_b), .d_i(d_ab),
    .valid_o(valid_o_b), .ready_i(ready_ab), .d_o(d_o_b),
    .last_o(last_o_b), .busy_o(busy_o_b)
  );

  shift_serializer #(.Width(32), .Depth(1), .LsbFirst(1)) u_c (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_c), .ready_o(ready_o_c), .d_i(d_c),
    .valid_o(valid_o_c), .ready_i(ready_c), .d_o(d_o_c),
    .last_o(last_o_c), .busy_o(busy_o_c)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: expected beat queues, {last, data}
  // ---------------------------------------------------------------------------
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  logic [32:0] q_c[$];

  // A word can be taken when nothing is pending, or when the only pending
  // beat is leaving this cycle.
  function automatic logic model_rdy(input int sz, input logic rdy, input logic r);
    return !r && ((sz == 0) || (sz == 1 && rdy));
  endfunction

  always @(posedge clk or posedge rst) begin
    logic ra, rb, rc;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end else begin
      ra = model_rdy(q_a.size(), ready_ab, 1'b0);
      rb = model_rdy(q_b.size(), ready_ab, 1'b0);
      rc = model_rdy(q_c.size(), ready_c, 1'b0);
      if (q_a.size() > 0 && ready_ab) void'(q_a.pop_front());
      if (q_b.size() > 0 && ready_ab) void'(q_b.pop_front());
      if (q_c.size() > 0 && ready_c)  void'(q_c.pop_front());
      if (valid_ab && ra) begin
        for (int k = 0; k < 8; k++) q_a.push_back({k == 7, d_ab[k*32 +: 32]});
      end
      if (valid_ab && rb) begin
        for (int k = 0; k < 8; k++) q_b.push_back({k == 7, d_ab[(7-k)*32 +: 32]});
      end
      if (valid_c && rc) begin
        q_c.push_back({1'b1, d_c});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [32:0] h;
    h = (q_a.size() > 0) ? q_a[0] : 33'd0;
    chk1("a_valid", valid_o_a, q_a.size() > 0);
    chk ("a_data",  d_o_a, h[31:0]);
    chk1("a_last",  last_o_a, h[32]);
    chk1("a_busy",  busy_o_a, q_a.size() > 0);
    chk1("a_ready", ready_o_a, model_rdy(q_a.size(), ready_ab, rst));

    h = (q_b.size() > 0) ? q_b[0] : 33'd0;
    chk1("b_valid", valid_o_b, q_b.size() > 0);
    chk ("b_data",  d_o_b, h[31:0]);
    chk1("b_last",  last_o_b, h[32]);
    chk1("b_busy",  busy_o_b, q_b.size() > 0);
    chk1("b_ready", ready_o_b, model_rdy(q_b.size(), ready_ab, rst));

    h = (q_c.size() > 0) ? q_c[0] : 33'd0;
    chk1("c_valid", valid_o_c, q_c.size() > 0);
    chk ("c_data",  d_o_c, h[31:0]);
    chk1("c_last",  last_o_c, h[32]);
    chk1("c_busy",  busy_o_c, q_c.size() > 0);
    chk1("c_ready", ready_o_c, model_rdy(q_c.size(), ready_c, rst));
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the edge that takes the presented word; returns 1 ns after it.
  task automatic wait_accept(input int which);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((which == 0 && ready_o_a) || (which == 1 && ready_o_c)) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL accept_timeout: got no ready_o expected ready_o=1 within 50 cycles (inst %0d)", which);
    end
  endtask

  function automatic logic [255:0] make_word(input int base);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(base + k);
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [255:0] w1, w2;

  initial begin
    w1 = make_word(1);
    w2 = make_word(9);
    rst = 1'b1;
    valid_ab = 1'b0; ready_ab = 1'b1; d_ab = '0;
    valid_c  = 1'b0; ready_c  = 1'b1; d_c  = '0;
    repeat (3) tick();
    chk1("lit_rst_ready", ready_o_a, 1'b0);
    chk1("lit_rst_valid", valid_o_a, 1'b0);
    rst = 1'b0;
    tick();
    chk1("lit_idle_ready", ready_o_a, 1'b1);

    // Single word, no backpressure.
    valid_ab = 1'b1; d_ab = w1;
    wait_accept(0);
    valid_ab = 1'b0; d_ab = '0;
    chk ("lit_first_a", d_o_a, 32'd1);
    chk ("lit_first_b", d_o_b, 32'd8);
    chk1("lit_first_last", last_o_a, 1'b0);
    repeat (7) tick();
    chk ("lit_eighth_a", d_o_a, 32'd8);
    chk1("lit_eighth_last_a", last_o_a, 1'b1);
    chk ("lit_eighth_b", d_o_b, 32'd1);
    chk1("lit_eighth_last_b", last_o_b, 1'b1);
    tick();
    chk1("lit_done_valid", valid_o_a, 1'b0);
    chk ("lit_done_data", d_o_a, 32'd0);
    repeat (2) tick();

    // Backpressure while beat 3 is presented.
    valid_ab = 1'b1; d_ab = w1;
    wait_accept(0);
    valid_ab = 1'b0;
    repeat (2) tick();
    ready_ab = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk ("lit_stall_a", d_o_a, 32'd3);
      chk1("lit_stall_last", last_o_a, 1'b0);
      chk1("lit_stall_ready", ready_o_a, 1'b0);
      chk ("lit_stall_b", d_o_b, 32'd6);
      @(posedge clk);
      #1;
    end
    ready_ab = 1'b1;
    tick();
    chk ("lit_resume_a", d_o_a, 32'd4);
    repeat (6) tick();

    // Back-to-back words with valid_i held.
    valid_ab = 1'b1; d_ab = w1;
    wait_accept(0);
    d_ab = w2;
    wait_accept(0);
    valid_ab = 1'b0; d_ab = '0;
    chk ("lit_b2b_a", d_o_a, 32'd9);
    chk ("lit_b2b_b", d_o_b, 32'd16);
    chk1("lit_b2b_busy", busy_o_a, 1'b1);
    repeat (9) tick();

    // Reset in the middle of a word.
    valid_ab = 1'b1; d_ab = w1;
    wait_accept(0);
    valid_ab = 1'b0;
    repeat (3) tick();
    chk ("lit_pre_rst_a", d_o_a, 32'd4);
    #1;
    rst = 1'b1;
    #1;
    chk1("lit_mid_rst_valid", valid_o_a, 1'b0);
    chk ("lit_mid_rst_data", d_o_a, 32'd0);
    chk1("lit_mid_rst_last", last_o_b, 1'b0);
    chk1("lit_mid_rst_busy", busy_o_b, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk1("lit_post_rst_ready", ready_o_a, 1'b1);
    chk1("lit_post_rst_valid", valid_o_a, 1'b0);
    tick();
    valid_ab = 1'b1; d_ab = w1;
    wait_accept(0);
    valid_ab = 1'b0;
    chk ("lit_post_rst_first", d_o_a, 32'd1);
    repeat (9) tick();

    // Depth=1: one word per cycle.
    valid_c = 1'b1; d_c = 32'hA;
    wait_accept(1);
    chk ("lit_d1_a", d_o_c, 32'hA);
    chk1("lit_d1_a_last", last_o_c, 1'b1);
    d_c = 32'hB;
    wait_accept(1);
    chk ("lit_d1_b", d_o_c, 32'hB);
    d_c = 32'hC;
    wait_accept(1);
    chk ("lit_d1_c", d_o_c, 32'hC);
    chk1("lit_d1_c_last", last_o_c, 1'b1);
    d_c = 32'hD;
    wait_accept(1);
    valid_c = 1'b0;
    ready_c = 1'b0;
    tick();
    chk ("lit_d1_stall", d_o_c, 32'hD);
    chk1("lit_d1_stall_ready", ready_o_c, 1'b0);
    ready_c = 1'b1;
    tick();
    chk1("lit_d1_drained", valid_o_c, 1'b0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
